// File: rtl/sb_rx_deframer.sv
// Sideband receive deframer: deserialises the UART-style sbrx stream,
// strips DLE/STX ... DLE/ETX framing and DLE stuffing, buffers one payload
// and replays it as a gap-free byte burst once the closing DLE ETX arrives.
module sb_rx_deframer #(
    parameter int         MAX_LEN = 16,
    parameter int         LEN_W   = 5,
    parameter logic [7:0] DLE     = 8'hFE,
    parameter logic [7:0] STX     = 8'h05,
    parameter logic [7:0] ETX     = 8'h40
) (
    input  logic             sb_clk,
    input  logic             rst,
    input  logic             sbrx,
    input  logic             enable,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_last,
    output logic [LEN_W-1:0] rx_len,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int              AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_PTR = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    localparam logic [1:0] ERR_STOP   = 2'd1;
    localparam logic [1:0] ERR_ESCAPE = 2'd2;
    localparam logic [1:0] ERR_OVFL   = 2'd3;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IDLE_DLE,
        ST_PAYLOAD,
        ST_PAYLOAD_DLE,
        ST_EMIT
    } fr_state_t;

    // Symbol receiver state
    rx_state_t        r_rx_state;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_byte;
    logic             r_byte_stb;
    logic             r_stop_err;

    // Frame FSM state and registered outputs
    fr_state_t        r_fr_state;
    logic [LEN_W-1:0] r_wr_ptr;
    logic [LEN_W-1:0] r_rd_ptr;
    logic [LEN_W-1:0] r_len;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_rx_last;
    logic             r_busy;
    logic             r_err;
    logic [1:0]       r_err_code;
    logic             r_pend_vld;
    logic [7:0]       r_pend;

    // Payload buffer
    logic [7:0]       r_mem [MAX_LEN];

    // Combinational helpers
    logic             w_in_stb;
    logic [7:0]       w_in_byte;
    logic             w_wr_en;
    logic [7:0]       w_wr_data;

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign rx_last  = r_rx_last;
    assign rx_len   = r_len;
    assign busy     = r_busy;
    assign err      = r_err;
    assign err_code = r_err_code;

    // Serial receiver: start bit, 8 data bits LSB first, stop bit on the 10th clock
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, matching real flip-flop behaviour.
    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_byte     <= 8'd0;
            r_byte_stb <= 1'b0;
            r_stop_err <= 1'b0;
        end else if (!enable) begin
            r_rx_state <= RX_IDLE;
            r_bit_cnt  <= 3'd0;
            r_byte_stb <= 1'b0;
            r_stop_err <= 1'b0;
        end else begin
            r_byte_stb <= 1'b0;
            r_stop_err <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!sbrx) begin
                        r_bit_cnt  <= 3'd0;
                        r_rx_state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    r_shift   <= {sbrx, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (sbrx) begin
                        r_byte     <= r_shift;
                        r_byte_stb <= 1'b1;
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_stop_err <= 1'b1;
                        r_rx_state <= RX_WAIT_HIGH;
                    end
                end
                RX_WAIT_HIGH: begin
                    // Line must return high before a new start bit is trusted
                    if (sbrx) begin
                        r_rx_state <= RX_IDLE;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Select the byte the frame FSM consumes: a held byte takes precedence after EMIT
    // NOTE: every combinationally assigned signal gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_in_stb  = 1'b0;
        w_in_byte = r_byte;
        if (r_fr_state != ST_EMIT) begin
            if (r_pend_vld) begin
                w_in_stb  = 1'b1;
                w_in_byte = r_pend;
            end else if (r_byte_stb) begin
                w_in_stb = 1'b1;
            end
        end
    end

    // Buffer write request: plain payload bytes and de-stuffed DLEs, while space remains
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_data = w_in_byte;
        if (enable && w_in_stb && (r_wr_ptr != MAX_PTR)) begin
            if ((r_fr_state == ST_PAYLOAD) && (w_in_byte != DLE)) begin
                w_wr_en = 1'b1;
            end else if ((r_fr_state == ST_PAYLOAD_DLE) && (w_in_byte == DLE)) begin
                w_wr_en   = 1'b1;
                w_wr_data = DLE;
            end
        end
    end

    // Payload buffer write port
    // NOTE: the buffer has no reset; pointers alone define which entries are
    // valid, so clearing the storage would only add reset fan-out.
    always_ff @(posedge sb_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wr_data;
        end
    end

    // Frame FSM: framing, de-stuffing, error reporting and burst replay
    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            r_fr_state <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_len      <= '0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_rx_last  <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_pend_vld <= 1'b0;
            r_pend     <= 8'd0;
        end else if (!enable) begin
            // Same as reset except the last reported length is kept
            r_fr_state <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_rx_last  <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_pend_vld <= 1'b0;
        end else begin
            r_err      <= 1'b0;
            r_err_code <= 2'd0;

            // A byte landing during the burst is parked and replayed afterwards
            if ((r_fr_state == ST_EMIT) && r_byte_stb) begin
                r_pend_vld <= 1'b1;
                r_pend     <= r_byte;
            end else if ((r_fr_state != ST_EMIT) && r_pend_vld) begin
                r_pend_vld <= 1'b0;
            end

            // Stop-bit errors are always reported; they only kill an open frame
            if (r_stop_err) begin
                r_err      <= 1'b1;
                r_err_code <= ERR_STOP;
            end

            case (r_fr_state)
                ST_IDLE: begin
                    if (w_in_stb && (w_in_byte == DLE)) begin
                        r_fr_state <= ST_IDLE_DLE;
                    end
                end
                ST_IDLE_DLE: begin
                    if (w_in_stb) begin
                        if (w_in_byte == STX) begin
                            r_fr_state <= ST_PAYLOAD;
                            r_wr_ptr   <= '0;
                            r_busy     <= 1'b1;
                        end else if (w_in_byte != DLE) begin
                            r_fr_state <= ST_IDLE;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (r_stop_err) begin
                        r_fr_state <= ST_IDLE;
                        r_busy     <= 1'b0;
                    end else if (w_in_stb) begin
                        if (w_in_byte == DLE) begin
                            r_fr_state <= ST_PAYLOAD_DLE;
                        end else if (r_wr_ptr == MAX_PTR) begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_OVFL;
                            r_fr_state <= ST_IDLE;
                            r_busy     <= 1'b0;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + ONE;
                        end
                    end
                end
                ST_PAYLOAD_DLE: begin
                    if (r_stop_err) begin
                        r_fr_state <= ST_IDLE;
                        r_busy     <= 1'b0;
                    end else if (w_in_stb) begin
                        if (w_in_byte == DLE) begin
                            if (r_wr_ptr == MAX_PTR) begin
                                r_err      <= 1'b1;
                                r_err_code <= ERR_OVFL;
                                r_fr_state <= ST_IDLE;
                                r_busy     <= 1'b0;
                            end else begin
                                r_wr_ptr   <= r_wr_ptr + ONE;
                                r_fr_state <= ST_PAYLOAD;
                            end
                        end else if (w_in_byte == ETX) begin
                            if (r_wr_ptr != '0) begin
                                // First burst byte goes out the cycle after the ETX strobe
                                r_fr_state <= ST_EMIT;
                                r_len      <= r_wr_ptr;
                                r_rx_valid <= 1'b1;
                                r_rx_data  <= r_mem[0];
                                r_rx_last  <= (r_wr_ptr == ONE);
                                r_rd_ptr   <= ONE;
                            end else begin
                                r_fr_state <= ST_IDLE;
                                r_busy     <= 1'b0;
                            end
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_ESCAPE;
                            r_fr_state <= ST_IDLE;
                            r_busy     <= 1'b0;
                        end
                    end
                end
                ST_EMIT: begin
                    if (r_rd_ptr == r_len) begin
                        r_rx_valid <= 1'b0;
                        r_rx_last  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_fr_state <= ST_IDLE;
                    end else begin
                        r_rx_valid <= 1'b1;
                        r_rx_data  <= r_mem[r_rd_ptr[AW-1:0]];
                        r_rx_last  <= (r_rd_ptr == (r_len - ONE));
                        r_rd_ptr   <= r_rd_ptr + ONE;
                    end
                end
                default: begin
                    r_fr_state <= ST_IDLE;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
